// File: rtl/gas_param_scheduler.sv
// gas_param_scheduler: round-robin temp/moles update path with meter tick and settle hold-off
module gas_param_scheduler #(
    parameter int TICK_DIV      = 250000,
    parameter int VAL_MIN       = 1,
    parameter int VAL_MAX       = 7,
    parameter int TEMP_INIT     = 3,
    parameter int MOL_INIT      = 3,
    parameter int SETTLE_TICKS  = 3,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       req_temp_up,
    input  logic       req_temp_dn,
    input  logic       req_mol_up,
    input  logic       req_mol_dn,
    input  logic [6:0] meter_q,
    output logic [2:0] temp,
    output logic [2:0] num_moles,
    output logic       meter_en,
    output logic       busy,
    output logic       sat_pulse,
    output logic       timeout_pulse
);
    localparam int DW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SETTLE_TICKS + 1);
    localparam int OW = $clog2(TIMEOUT_TICKS + 1);
    typedef enum logic [1:0] {IDLE, APPLY, SETTLE} state_t;
    state_t state;
    logic [DW-1:0] div;
    logic [SW-1:0] stable, stable_n;
    logic [OW-1:0] tmo, tmo_n;
    logic [6:0] last_q;
    logic [3:0] pend, req, clr;
    logic rr, grp, win, t_pend, m_pend, up, dn;
    logic [2:0] cur, nxt;
    assign req = {req_mol_dn, req_mol_up, req_temp_dn, req_temp_up};
    assign t_pend = |pend[1:0];
    assign m_pend = |pend[3:2];
    assign win = (t_pend && m_pend) ? rr : m_pend;
    assign up = grp ? pend[2] : pend[0];
    assign dn = grp ? pend[3] : pend[1];
    assign cur = grp ? num_moles : temp;
    assign nxt = up ? cur + 3'd1 : cur - 3'd1;
    // A same-group up/dn pair is cancelled by clearing both bits together.
    assign clr = (state == APPLY) ? (grp ? {dn, up, 2'b00} : {2'b00, dn, up}) : 4'b0000;
    assign meter_en = div == DW'(TICK_DIV - 1);
    assign busy = state != IDLE;
    assign stable_n = (meter_q == last_q) ? stable + 1'b1 : '0;
    assign tmo_n = tmo + 1'b1;
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state         <= IDLE;
            div           <= '0;
            stable        <= '0;
            tmo           <= '0;
            last_q        <= '0;
            pend          <= '0;
            rr            <= 1'b0;
            grp           <= 1'b0;
            temp          <= 3'(TEMP_INIT);
            num_moles     <= 3'(MOL_INIT);
            sat_pulse     <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            div           <= meter_en ? '0 : div + 1'b1;
            pend          <= (pend & ~clr) | req;
            sat_pulse     <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: if (t_pend || m_pend) begin
                    grp   <= win;
                    rr    <= ~win;
                    state <= APPLY;
                end
                APPLY: begin
                    state <= IDLE;
                    if (up != dn) begin
                        if (cur == (up ? 3'(VAL_MAX) : 3'(VAL_MIN))) sat_pulse <= 1'b1;
                        else begin
                            if (grp) num_moles <= nxt;
                            else temp <= nxt;
                            state  <= SETTLE;
                            stable <= '0;
                            tmo    <= '0;
                            last_q <= meter_q;
                        end
                    end
                end
                SETTLE: if (meter_en) begin
                    stable <= stable_n;
                    tmo    <= tmo_n;
                    last_q <= meter_q;
                    // Settling takes priority when it coincides with the timeout tick.
                    if (stable_n == SW'(SETTLE_TICKS)) state <= IDLE;
                    else if (tmo_n == OW'(TIMEOUT_TICKS)) begin
                        state         <= IDLE;
                        timeout_pulse <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gas_param_scheduler.sv
// tb_gas_param_scheduler: directed vectors for the temp/moles scheduler with TICK_DIV=4
module tb_gas_param_scheduler;
    logic clk = 1'b0;
    logic clearn = 1'b0;
    logic req_temp_up = 1'b0, req_temp_dn = 1'b0, req_mol_up = 1'b0, req_mol_dn = 1'b0;
    logic [6:0] meter_q = 7'd0;
    logic [2:0] temp, num_moles;
    logic meter_en, busy, sat_pulse, timeout_pulse;
    int errs = 0;
    int checks = 0;

    gas_param_scheduler #(.TICK_DIV(4)) dut (
        .clk(clk), .clearn(clearn),
        .req_temp_up(req_temp_up), .req_temp_dn(req_temp_dn),
        .req_mol_up(req_mol_up), .req_mol_dn(req_mol_dn),
        .meter_q(meter_q), .temp(temp), .num_moles(num_moles),
        .meter_en(meter_en), .busy(busy), .sat_pulse(sat_pulse),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // r = {mol_dn, mol_up, temp_dn, temp_up}; returns at the negedge after the sampling edge
    task automatic pulse(input logic [3:0] r);
        @(negedge clk);
        {req_mol_dn, req_mol_up, req_temp_dn, req_temp_up} = r;
        @(negedge clk);
        {req_mol_dn, req_mol_up, req_temp_dn, req_temp_up} = 4'b0000;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy, 0);
        check({tag, "_no_tmo"}, timeout_pulse, 0);
    endtask

    initial begin
        int cnt;
        int n;
        meter_q = 7'd45;
        #12;
        check("rst_temp", temp, 3);
        check("rst_mol", num_moles, 3);
        check("rst_busy", busy, 0);
        check("rst_en", meter_en, 0);
        @(negedge clk);
        clearn = 1'b1;
        cnt = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt += int'(meter_en);
            n += int'(busy);
        end
        check("en_count", cnt, 5);
        check("idle_busy", n, 0);
        check("idle_temp", temp, 3);

        pulse(4'b0001);
        @(negedge clk);
        check("e1_temp", temp, 3);
        check("e1_busy", busy, 1);
        @(negedge clk);
        check("e2_temp", temp, 4);
        check("e2_busy", busy, 1);
        wait_idle("up1");

        pulse(4'b1000);
        repeat (2) @(negedge clk);
        check("mdn_mol", num_moles, 2);
        wait_idle("mdn");

        // rr points at temp: temp first, moles after settle
        pulse(4'b0101);
        repeat (2) @(negedge clk);
        check("pairB_temp", temp, 5);
        check("pairB_mol_hold", num_moles, 2);
        wait_idle("pairB1");
        repeat (2) @(negedge clk);
        check("pairB_mol", num_moles, 3);
        wait_idle("pairB2");

        pulse(4'b0010);
        repeat (2) @(negedge clk);
        check("tdn_temp", temp, 4);
        wait_idle("tdn");

        // rr now points at moles
        pulse(4'b0101);
        repeat (2) @(negedge clk);
        check("pairC_mol", num_moles, 4);
        check("pairC_temp_hold", temp, 4);
        wait_idle("pairC1");
        repeat (2) @(negedge clk);
        check("pairC_temp", temp, 5);
        wait_idle("pairC2");

        pulse(4'b0001);
        repeat (2) @(negedge clk);
        wait_idle("to6");
        pulse(4'b0001);
        repeat (2) @(negedge clk);
        check("to7_temp", temp, 7);
        wait_idle("to7");

        pulse(4'b0001);
        @(negedge clk);
        check("sat_e1_busy", busy, 1);
        @(negedge clk);
        check("sat_temp", temp, 7);
        check("sat_pulse", sat_pulse, 1);
        check("sat_no_settle", busy, 0);
        @(negedge clk);
        check("sat_pulse_end", sat_pulse, 0);

        pulse(4'b1100);
        repeat (2) @(negedge clk);
        check("cancel_mol", num_moles, 4);
        check("cancel_sat", sat_pulse, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            n += int'(busy);
            @(negedge clk);
        end
        check("cancel_cleared", n, 0);
        check("cancel_mol2", num_moles, 4);

        pulse(4'b0010);
        repeat (2) @(negedge clk);
        check("tmo_temp", temp, 6);
        cnt = 0;
        n = 0;
        while (busy && n < 400) begin
            if (meter_en) begin
                cnt++;
                meter_q ^= 7'h01;
            end
            @(negedge clk);
            n++;
        end
        check("tmo_idle", busy, 0);
        check("tmo_pulse", timeout_pulse, 1);
        check("tmo_ticks", cnt, 64);
        @(negedge clk);
        check("tmo_pulse_end", timeout_pulse, 0);

        pulse(4'b0100);
        repeat (2) @(negedge clk);
        check("pre_rst_mol", num_moles, 5);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 clearn = 1'b0;
        #1;
        check("arst_temp", temp, 3);
        check("arst_mol", num_moles, 3);
        check("arst_busy", busy, 0);
        check("arst_en", meter_en, 0);
        @(negedge clk);
        clearn = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n += int'(busy);
        end
        check("post_rst_idle", n, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
